// File: rtl/erasable_pkg.sv
// Shared definitions for the erasable-memory word store.
//   state_e            controller states: SCRUB (post-reset fill) and IDLE (servicing)
//   ERR_*              bit positions inside the sticky err vector
//   INIT_WORD_DEFAULT  power-on fill pattern used unless overridden
package erasable_pkg;

  typedef enum logic [0:0] {
    SCRUB = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int ERR_COLLIDE = 0;
  localparam int ERR_BUSY    = 1;
  localparam int ERR_RANGE   = 2;

  localparam logic [15:0] INIT_WORD_DEFAULT = 16'o40000;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline for erasable_sram_sync.
// Delays the read-accept strobe by READ_LAT cycles and carries the word
// captured by the RAM output register alongside it.
//   SIM_CLK  clock
//   SIM_RST  synchronous active-high reset; flushes every valid stage
//   valid_i  read accepted on this edge
//   data_i   RAM output register (already one cycle behind the accept)
//   valid_o  one-cycle pulse READ_LAT cycles after the accept
//   data_o   returned word, forced to 0 whenever valid_o is low
module sram_rd_pipe #(
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [READ_LAT-1:0] valid_q;
  logic [DATA_W-1:0]   data_last;

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= valid_i;
      for (int k = 1; k < READ_LAT; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // The first data stage is the RAM output register in the parent, so the
  // data chain here is one stage shorter than the valid chain.
  if (READ_LAT == 1) begin : g_direct
    assign data_last = data_i;
  end else begin : g_chain
    logic [DATA_W-1:0] data_q [READ_LAT-1];

    always_ff @(posedge SIM_CLK) begin
      data_q[0] <= data_i;
      for (int k = 1; k < READ_LAT - 1; k++) begin
        data_q[k] <= data_q[k-1];
      end
    end

    assign data_last = data_q[READ_LAT-2];
  end

  assign valid_o = valid_q[READ_LAT-1];
  assign data_o  = valid_o ? data_last : '0;

endmodule

// File: rtl/erasable_sram_sync.sv
// Clocked erasable-memory word store with byte-lane writes, a pipelined
// read return and a hardware scrub that fills every word after reset.
//   SIM_CLK  clock
//   SIM_RST  synchronous active-high reset; restarts the scrub
//   en       chip enable; rd/wr are ignored while low
//   rd, wr   read / write request
//   be       byte-lane write enables, be[k] covers bits [k*LANE_W +: LANE_W]
//   addr     word address; values >= DEPTH are rejected
//   wdata    write data
//   rdata    read data, 0 unless rvalid
//   rvalid   one-cycle pulse READ_LAT cycles after an accepted read
//   busy     high while the scrub runs
//   err      sticky {range, busy, collision} flags
//   err_clr  clears err; errors raised in the same cycle still set
module erasable_sram_sync
  import erasable_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                LANE_W    = 8,
  parameter int                LANES     = DATA_W / LANE_W,
  parameter int                DEPTH     = 2048,
  parameter int                ADDR_W    = 16,
  parameter int                READ_LAT  = 1,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(INIT_WORD_DEFAULT)
) (
  input  logic              SIM_CLK,
  input  logic              SIM_RST,
  input  logic              en,
  input  logic              rd,
  input  logic              wr,
  input  logic [LANES-1:0]  be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic [2:0]        err,
  input  logic              err_clr
);

  localparam int              CNT_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        err_q, err_d, err_new;

  logic              scrubbing, idle, req, addr_oor;
  logic              rd_acc, wr_acc, scrub_we;
  logic [CNT_W-1:0]  addr_idx, wr_idx;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] ram_rdata_q;
  logic [LANES-1:0]  lane_we;

  assign scrubbing = (state_q == SCRUB);
  assign idle      = (state_q == IDLE);
  assign req       = en & (rd | wr);
  // Compare with one spare bit so the full address port is range-checked.
  assign addr_oor  = ({1'b0, addr} >= DEPTH_EXT);
  assign addr_idx  = addr[CNT_W-1:0];

  // Reset wins over any request on the same edge, so nothing reaches the array.
  assign rd_acc   = idle & en & rd & ~wr & ~addr_oor & ~SIM_RST;
  assign wr_acc   = idle & en & wr & ~rd & ~addr_oor & ~SIM_RST;
  assign scrub_we = scrubbing & ~SIM_RST;

  assign wr_idx  = scrubbing ? cnt_q : addr_idx;
  assign wr_word = scrubbing ? INIT_WORD : wdata;

  // One narrow array per lane keeps the byte-enable write a plain per-RAM
  // write enable, with the registered read giving the first pipeline stage.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] mem_q [DEPTH];

    assign lane_we[gi] = scrub_we | (wr_acc & be[gi]);

    always_ff @(posedge SIM_CLK) begin
      if (lane_we[gi]) begin
        mem_q[wr_idx] <= wr_word[gi*LANE_W +: LANE_W];
      end
      if (rd_acc) begin
        ram_rdata_q[gi*LANE_W +: LANE_W] <= mem_q[addr_idx];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (scrubbing) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(DEPTH - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Requests while scrubbing only flag busy; range and collision are judged
  // in IDLE and may fire together.
  always_comb begin
    err_new              = '0;
    err_new[ERR_COLLIDE] = idle & req & rd & wr;
    err_new[ERR_BUSY]    = scrubbing & req;
    err_new[ERR_RANGE]   = idle & req & addr_oor;
    err_d                = (err_clr ? 3'b000 : err_q) | err_new;
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q <= SCRUB;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  sram_rd_pipe #(
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_rd_pipe (
    .SIM_CLK(SIM_CLK),
    .SIM_RST(SIM_RST),
    .valid_i(rd_acc),
    .data_i (ram_rdata_q),
    .valid_o(rvalid),
    .data_o (rdata)
  );

  assign busy = scrubbing;
  assign err  = err_q;

endmodule

// File: tb/tb_erasable_sram_sync.sv
module tb_erasable_sram_sync;

  localparam int          DEPTH = 2048;
  localparam logic [15:0] INIT  = 16'o40000;

  logic        clk = 1'b0;
  logic        rst, en, rd, wr, err_clr;
  logic [1:0]  be;
  logic [15:0] addr, wdata;

  logic [15:0] rdata_w  [3];
  logic        rvalid_w [3];
  logic        busy_w   [3];
  logic [2:0]  err_w    [3];

  always #5 clk = ~clk;

  erasable_sram_sync #(.READ_LAT(1)) u_lat1 (
    .SIM_CLK(clk), .SIM_RST(rst), .en(en), .rd(rd), .wr(wr), .be(be),
    .addr(addr), .wdata(wdata), .rdata(rdata_w[0]), .rvalid(rvalid_w[0]),
    .busy(busy_w[0]), .err(err_w[0]), .err_clr(err_clr));

  erasable_sram_sync #(.READ_LAT(2)) u_lat2 (
    .SIM_CLK(clk), .SIM_RST(rst), .en(en), .rd(rd), .wr(wr), .be(be),
    .addr(addr), .wdata(wdata), .rdata(rdata_w[1]), .rvalid(rvalid_w[1]),
    .busy(busy_w[1]), .err(err_w[1]), .err_clr(err_clr));

  erasable_sram_sync #(.READ_LAT(3)) u_lat3 (
    .SIM_CLK(clk), .SIM_RST(rst), .en(en), .rd(rd), .wr(wr), .be(be),
    .addr(addr), .wdata(wdata), .rdata(rdata_w[2]), .rvalid(rvalid_w[2]),
    .busy(busy_w[2]), .err(err_w[2]), .err_clr(err_clr));

  // Reference model: word array, scrub countdown, sticky errors and a
  // history of accepted reads tagged by the edge that accepted them.
  logic [15:0] mem_m [DEPTH];
  int          scrub_left = 0;
  logic [2:0]  err_m = 3'b000;
  bit          hv [8];
  logic [15:0] hd [8];
  int          ht [8];
  int          edge_n = 0;

  int n_asserts = 0;
  int n_fails   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit rq, input bit wq,
                     input logic [1:0] b, input logic [15:0] a,
                     input logic [15:0] wd, input bit clr);
    logic [2:0]  newe;
    bit          acc;
    logic [15:0] d;
    int          idx, slot;
    bit          expv;
    logic [15:0] expd;
    rst = r; en = e; rd = rq; wr = wq; be = b; addr = a; wdata = wd; err_clr = clr;
    acc = 1'b0; d = '0; newe = '0;
    if (r) begin
      scrub_left = DEPTH;
      err_m = '0;
      for (int i = 0; i < 8; i++) hv[i] = 1'b0;
      // Nothing can reach the array until the scrub ends, so it is simply full of INIT.
      for (int i = 0; i < DEPTH; i++) mem_m[i] = INIT;
    end else begin
      if (e && (rq || wq)) begin
        if (scrub_left > 0) newe[1] = 1'b1;
        else begin
          if (rq && wq) newe[0] = 1'b1;
          if (int'(a) >= DEPTH) newe[2] = 1'b1;
          if (newe == 3'b000) begin
            if (wq) begin
              for (int k = 0; k < 2; k++)
                if (b[k]) mem_m[a][k*8 +: 8] = wd[k*8 +: 8];
            end else begin
              acc = 1'b1;
              d = mem_m[a];
            end
          end
        end
      end
      err_m = (clr ? 3'b000 : err_m) | newe;
      if (scrub_left > 0) scrub_left--;
    end
    hv[edge_n % 8] = acc;
    hd[edge_n % 8] = d;
    ht[edge_n % 8] = edge_n;
    @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      idx  = edge_n - l;
      expv = 1'b0;
      expd = '0;
      if (idx >= 0) begin
        slot = idx % 8;
        if (ht[slot] == idx && hv[slot]) begin
          expv = 1'b1;
          expd = hd[slot];
        end
      end
      chk($sformatf("rvalid_lat%0d@%0d", l + 1, edge_n), rvalid_w[l], expv);
      chk($sformatf("rdata_lat%0d@%0d", l + 1, edge_n), rdata_w[l], expd);
      chk($sformatf("busy_lat%0d@%0d", l + 1, edge_n), busy_w[l], scrub_left > 0);
      chk($sformatf("err_lat%0d@%0d", l + 1, edge_n), err_w[l], err_m);
    end
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 2'b00, 16'd0, 16'd0, 0);
  endtask

  task automatic rd_req(input logic [15:0] a);
    cyc(0, 1, 1, 0, 2'b00, a, 16'd0, 0);
  endtask

  task automatic wr_req(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] b);
    cyc(0, 1, 0, 1, b, a, wd, 0);
  endtask

  task automatic clear_err();
    cyc(0, 0, 0, 0, 2'b00, 16'd0, 16'd0, 1);
  endtask

  // Runs the scrub to completion, optionally writing during it, and checks its length.
  task automatic run_scrub(input string tag, input int poke_at);
    int k;
    k = 0;
    while (busy_w[0] && k < DEPTH + 8) begin
      if (k == poke_at) begin
        wr_req(16'd9, 16'hFFFF, 2'b11);
        $display("scrub write during busy at cycle %0d: err=%b", k, err_w[0]);
        chk("err_busy_write", err_w[0], 3'b010);
      end else begin
        idle(1);
      end
      k++;
    end
    $display("%s: busy for %0d cycles", tag, k);
    chk(tag, k, DEPTH);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rd = 1'b0; wr = 1'b0; be = '0;
    addr = '0; wdata = '0; err_clr = 1'b0;

    repeat (3) cyc(1, 0, 0, 0, 2'b00, 16'd0, 16'd0, 0);
    $display("reset: busy=%b rvalid=%b err=%b", busy_w[0], rvalid_w[0], err_w[0]);
    chk("reset_busy", busy_w[0], 1'b1);
    run_scrub("scrub_len_first", 10);
    clear_err();

    rd_req(16'd0);
    $display("read addr 0: rvalid=%b rdata=%h", rvalid_w[0], rdata_w[0]);
    chk("init_addr0", rdata_w[0], INIT);
    rd_req(16'(DEPTH - 1));
    $display("read addr %0d: rvalid=%b rdata=%h", DEPTH - 1, rvalid_w[0], rdata_w[0]);
    chk("init_addr_top", rdata_w[0], INIT);
    rd_req(16'd9);
    $display("read addr 9 (written while busy): rdata=%h", rdata_w[0]);
    chk("busy_write_dropped", rdata_w[0], INIT);
    idle(3);

    wr_req(16'd5, 16'h1234, 2'b11);
    wr_req(16'd5, 16'hABCD, 2'b01);
    rd_req(16'd5);
    $display("lane merge addr 5: rdata=%h", rdata_w[0]);
    chk("lane_merge", rdata_w[0], 16'h12CD);
    idle(3);

    wr_req(16'd1, 16'hA1A1, 2'b11);
    wr_req(16'd2, 16'hB2B2, 2'b11);
    wr_req(16'd3, 16'hC3C3, 2'b11);
    rd_req(16'd1);
    rd_req(16'd2);
    rd_req(16'd3);
    $display("lat3 pipe beat 0: rvalid=%b rdata=%h", rvalid_w[2], rdata_w[2]);
    chk("lat3_beat0", rdata_w[2], 16'hA1A1);
    idle(1);
    $display("lat3 pipe beat 1: rvalid=%b rdata=%h", rvalid_w[2], rdata_w[2]);
    chk("lat3_beat1", rdata_w[2], 16'hB2B2);
    idle(1);
    $display("lat3 pipe beat 2: rvalid=%b rdata=%h", rvalid_w[2], rdata_w[2]);
    chk("lat3_beat2", rdata_w[2], 16'hC3C3);
    idle(1);
    chk("lat3_after", rvalid_w[2], 1'b0);

    cyc(0, 1, 1, 1, 2'b11, 16'd7, 16'hFFFF, 0);
    $display("collision addr 7: err=%b rvalid=%b", err_w[0], rvalid_w[0]);
    chk("collide_err", err_w[0], 3'b001);
    rd_req(16'd7);
    chk("collide_no_write", rdata_w[0], INIT);
    clear_err();
    chk("err_cleared", err_w[0], 3'b000);

    rd_req(16'(DEPTH));
    $display("read addr %0d: err=%b rvalid=%b", DEPTH, err_w[0], rvalid_w[0]);
    chk("range_err", err_w[0], 3'b100);
    chk("range_no_rvalid", rvalid_w[0], 1'b0);
    cyc(0, 1, 1, 1, 2'b11, 16'(DEPTH + 3), 16'h0, 0);
    chk("range_collide_err", err_w[0], 3'b101);
    cyc(0, 1, 1, 0, 2'b00, 16'hFFFF, 16'h0, 1);
    $display("clear with simultaneous range error: err=%b", err_w[0]);
    chk("clear_vs_new", err_w[0], 3'b100);
    clear_err();

    wr_req(16'd20, 16'h1111, 2'b11);
    rd_req(16'd20);
    wr_req(16'd20, 16'h2222, 2'b11);
    idle(3);
    rd_req(16'd20);
    $display("hazard reread addr 20: rdata=%h", rdata_w[0]);
    idle(3);

    for (int i = 0; i < 400; i++) begin
      int          sel;
      logic [15:0] a;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 16'(DEPTH + $urandom_range(0, 100));
      else if (sel == 1) a = 16'hFFFF;
      else               a = 16'($urandom_range(0, 15));
      cyc(0, $urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom),
          2'($urandom), a, 16'($urandom), $urandom_range(0, 9) == 0);
      $display("rand %0d: addr=%h rvalid=%b%b%b err=%b", i, a,
               rvalid_w[0], rvalid_w[1], rvalid_w[2], err_w[0]);
    end
    idle(4);

    rd_req(16'd5);
    rd_req(16'd6);
    cyc(1, 0, 0, 0, 2'b00, 16'd0, 16'd0, 0);
    $display("reset mid-read: rvalid=%b%b%b", rvalid_w[0], rvalid_w[1], rvalid_w[2]);
    chk("flush_lat2", rvalid_w[1], 1'b0);
    idle(2);
    idle(98);
    cyc(1, 0, 0, 0, 2'b00, 16'd0, 16'd0, 0);
    run_scrub("scrub_len_restart", -1);
    rd_req(16'd5);
    $display("after rescrub addr 5: rdata=%h", rdata_w[0]);
    chk("rescrub_addr5", rdata_w[0], INIT);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
